// File: rtl/io_serial_tx_pkg.sv
// Shared definitions for the serial console transmitter: FSM encodings and
// default bit timing.
package io_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int FRAME_DATA_BITS      = 8;

endpackage

// File: rtl/io_serial_tx_byte_fifo.sv
// Synchronous byte FIFO with a show-ahead head: rd_data is the oldest entry and
// is consumed by asserting rd_en in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             rd_ok;
  logic             wr_ok;

  assign full  = (level_reg == LW'(DEPTH));
  assign empty = (level_reg == '0);
  assign level = level_reg;

  // A pop in the same cycle frees the slot, so a write into a full FIFO is legal then.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        level_reg <= level_reg + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        level_reg <= level_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_serial_tx.sv
// Serial console transmitter: buffers output-port bytes and sends them as
// LSB-first 8N1 frames on a registered, idle-high tx line.
module io_serial_tx
  import io_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_en,
  output logic                          tx,
  output logic                          full,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  tx_state_t     state_reg, state_next;
  logic [BW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          overflow_reg;

  logic          fifo_rd;
  logic [7:0]    fifo_rd_data;
  logic          fifo_empty;
  logic          baud_max;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .level   (level),
    .full    (full),
    .empty   (fifo_empty)
  );

  assign baud_max = (baud_cnt_reg == BAUD_MAX);

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    fifo_rd       = 1'b0;
    // tx_next is the line level for the state being entered, so tx stays a clean flop.
    case (state_reg)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          fifo_rd       = 1'b1;
          shift_next    = fifo_rd_data;
          bit_cnt_next  = '0;
          baud_cnt_next = '0;
          state_next    = ST_START;
          tx_next       = 1'b0;
        end
      end
      ST_START: begin
        if (baud_max) begin
          baud_cnt_next = '0;
          state_next    = ST_DATA;
          tx_next       = shift_reg[0];
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_max) begin
          baud_cnt_next = '0;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_cnt_next = bit_cnt_reg + 1'b1;
            tx_next      = shift_reg[1];
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_max) begin
          baud_cnt_next = '0;
          state_next    = ST_IDLE;
          tx_next       = 1'b1;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      // Sticky until reset: a write lost because no slot was free this cycle.
      if (wr_en && full && !fifo_rd) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign tx       = tx_reg;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != ST_IDLE) || (level != '0);

endmodule

// File: tb/tb_io_serial_tx.sv
// Randomised bench for io_serial_tx: a timing-level reference model predicts
// every output each cycle, and a line decoder checks frames against a scoreboard.
module tb_io_serial_tx;

  localparam int C     = 4;
  localparam int D     = 8;
  localparam int LW    = $clog2(D) + 1;
  localparam int FRAME = 10 * C;
  localparam int FAR   = -100000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          tx;
  logic          full;
  logic          busy;
  logic          overflow;
  logic [LW-1:0] level;

  io_serial_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .tx       (tx),
    .full     (full),
    .busy     (busy),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each accepted byte gets the edge at which it will be popped.
  int         pend_pop[$];
  logic [7:0] pend_byte[$];
  logic [7:0] exp_q[$];
  int         last_pop_sched = FAR;
  int         last_started   = FAR;
  logic [7:0] last_byte      = 8'h00;
  bit         ovf_m          = 1'b0;
  int         edge_cnt       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, req);
    end
  endtask

  function automatic void model_reset();
    pend_pop.delete();
    pend_byte.delete();
    exp_q.delete();
    last_pop_sched = FAR;
    last_started   = FAR;
    ovf_m          = 1'b0;
  endfunction

  function automatic void model_edge(input int e, input bit we, input logic [7:0] d);
    bit pop_now;
    int lvl;
    int p;
    lvl     = pend_pop.size();
    pop_now = (lvl > 0) && (pend_pop[0] == e);
    if (pop_now) begin
      last_started = e;
      last_byte    = pend_byte[0];
      void'(pend_pop.pop_front());
      void'(pend_byte.pop_front());
    end
    if (we) begin
      if (lvl < D || pop_now) begin
        p = (e + 1 > last_pop_sched + FRAME + 1) ? e + 1 : last_pop_sched + FRAME + 1;
        last_pop_sched = p;
        pend_pop.push_back(p);
        pend_byte.push_back(d);
        exp_q.push_back(d);
      end else begin
        ovf_m = 1'b1;
      end
    end
  endfunction

  task automatic check_outputs(input int e);
    int   dd;
    int   slot;
    logic exp_tx;
    logic exp_busy;
    dd     = e - last_started;
    exp_tx = 1'b1;
    if (dd >= 0 && dd < FRAME) begin
      slot = dd / C;
      if (slot == 0)      exp_tx = 1'b0;
      else if (slot <= 8) exp_tx = last_byte[slot-1];
    end
    exp_busy = (pend_pop.size() != 0) || (dd >= 0 && dd < FRAME);
    check("tx", 32'(tx), 32'(exp_tx));
    check("level", 32'(level), 32'(pend_pop.size()));
    check("full", 32'(full), 32'(pend_pop.size() == D));
    check("busy", 32'(busy), 32'(exp_busy));
    check("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  // One clock: inputs change at negedge, outputs checked 1 time unit after posedge.
  task automatic step(input bit we, input logic [7:0] d);
    int e;
    @(negedge clk);
    wr_en   = we;
    wr_data = d;
    e = edge_cnt + 1;
    model_edge(e, we, d);
    @(posedge clk);
    edge_cnt = e;
    #1;
    check_outputs(e);
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((pend_pop.size() > 0 || edge_cnt - last_started < FRAME) && guard < 3000) begin
      step(1'b0, 8'h00);
      guard++;
    end
    check("drain_bound", 32'(guard < 3000), 32'd1);
    idle(3);
  endtask

  // Asserts reset between clock edges; outputs must return to idle immediately.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    model_reset();
    @(posedge clk);
    edge_cnt++;
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  // Line decoder: samples mid-bit and scores each received byte.
  initial begin
    int         cnt;
    int         slot;
    bit         act;
    logic [7:0] sh;
    logic [7:0] e;
    act = 1'b0;
    cnt = 0;
    sh  = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        act = 1'b0;
        continue;
      end
      if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
      end
      if (act && (cnt % C) == C / 2) begin
        slot = cnt / C;
        if (slot == 0) begin
          check("start_bit", 32'(tx), 32'd0);
        end else if (slot <= 8) begin
          sh[slot-1] = tx;
        end else begin
          check("stop_bit", 32'(tx), 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_unexpected: got %0h, expected no frame", sh);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", 32'(sh), 32'(e));
          end
          act = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    @(posedge clk);
    edge_cnt++;
    #1;
    pulse_reset();
    idle(2);

    // Single byte
    step(1'b1, 8'hA5);
    idle(45);

    // Burst of three
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    check("burst_level_peak", 32'(level), 32'd2);
    drain();

    // Overflow: ten back-to-back writes into an 8-deep FIFO
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h10 + i));
      if (i == 8) check("full_after_9th", 32'(full), 32'd1);
    end
    check("overflow_after_10th", 32'(overflow), 32'd1);
    drain();
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Write into a full FIFO exactly on the pop edge
    pulse_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h40 + i));
    guard = 0;
    while ((pend_pop.size() == 0 || pend_pop[0] != edge_cnt + 1) && guard < 200) begin
      step(1'b0, 8'h00);
      guard++;
    end
    check("pop_edge_found", 32'(guard < 200), 32'd1);
    step(1'b1, 8'h55);
    check("full_pop_level", 32'(level), 32'(D));
    check("full_pop_overflow", 32'(overflow), 32'd0);
    drain();

    // Reset during data bit 3 with three bytes queued
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i));
    guard = 0;
    while (edge_cnt != last_started + 4 * C + 1 && guard < 200) begin
      step(1'b0, 8'h00);
      guard++;
    end
    check("reach_bit3", 32'(guard < 200), 32'd1);
    pulse_reset();
    idle(60);
    step(1'b1, 8'h3C);
    drain();

    // Pointer wrap: 20 random bytes keeping occupancy at most 2
    for (int i = 0; i < 20; i++) begin
      guard = 0;
      while (pend_pop.size() >= 2 && guard < 200) begin
        step(1'b0, 8'h00);
        guard++;
      end
      idle($urandom_range(0, 20));
      step(1'b1, 8'($urandom));
    end
    drain();

    // Random write traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 5) == 0, 8'($urandom));
    end
    drain();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
